uart_tx_mmio: RTL and testbench

//  UART transmit end of the core's MMIO console path. Bytes the memory stage writes via mmio_wea/mmio_dat
//  are buffered in a FIFO and serialised on tx as 8N1 frames. Each completed frame is reported on mmio_read.

---
 rtl/uart_tx_mmio.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   UART transmit end of the MMIO console path. Bytes written by the memory
//   stage are queued in a small FIFO and serialised on tx as 8N1 frames
//   (start bit, 8 data bits LSB first, stop bit). Each finished frame is
//   reported with a one-cycle pulse on mmio_read.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   FIFO_DEPTH    byte FIFO entries (power of 2, >= 2)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   Rst        in   synchronous active-high reset
//   mmio_wea   in   write strobe, one byte per asserted cycle
//   mmio_dat   in   write data, only [7:0] is transmitted
//   tx         out  serial line, idle high, registered
//   mmio_read  out  one-cycle pulse as each frame's stop bit completes
//   tx_busy    out  FSM not idle or FIFO non-empty
//   fifo_full  out  FIFO holds FIFO_DEPTH bytes
//   overflow   out  sticky flag, a write was dropped; cleared only by Rst
module uart_tx_mmio #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        mmio_wea,
   input  logic [31:0] mmio_dat,
   output logic        tx,
   output logic        mmio_read,
   output logic        tx_busy,
   output logic        fifo_full,
   output logic        overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_q,     state_d;
   logic [BW-1:0]   baud_cnt_q,  baud_cnt_d;
   logic [2:0]      bit_idx_q,   bit_idx_d;
   logic [7:0]      shreg_q,     shreg_d;
   logic            tx_q,        tx_d;
   logic            mmio_read_q, mmio_read_d;
   logic            overflow_q,  overflow_d;
   logic [PW-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0]   count_q,     count_d;
   logic [7:0]      fifo_mem_q [FIFO_DEPTH];

   logic            push;
   logic            pop;
   logic            fifo_nonempty;
   logic [7:0]      fifo_head;
   logic            baud_end;
   logic            unused_dat_hi;

   assign unused_dat_hi = ^mmio_dat[31:8];

   // Acceptance looks only at the pre-edge count, so a pop in the same
   // cycle never makes room for a write that arrives while full.
   assign push          = mmio_wea && (count_q != DEPTH_C);
   assign fifo_nonempty = (count_q != '0);
   assign fifo_head     = fifo_mem_q[rd_ptr_q];
   assign baud_end      = (baud_cnt_q == BAUD_LAST);

   always_comb begin
      overflow_d = overflow_q | (mmio_wea & ~push);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q + BW'(1);
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      tx_d        = tx_q;
      mmio_read_d = 1'b0;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d       = 1'b1;
            baud_cnt_d = '0;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               shreg_d = fifo_head;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               tx_d       = shreg_q[0];
               bit_idx_d  = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // Next bit is bit 1 of the current register, i.e. bit 0
                  // after the shift.
                  shreg_d   = {1'b0, shreg_q[7:1]};
                  tx_d      = shreg_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_cnt_d  = '0;
               mmio_read_d = 1'b1;
               // Chain straight into the next frame when data is waiting.
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shreg_d = fifo_head;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         tx_q        <= 1'b1;
         mmio_read_q <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         tx_q        <= tx_d;
         mmio_read_q <= mmio_read_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Data storage carries no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= mmio_dat[7:0];
      end
   end

   assign tx        = tx_q;
   assign mmio_read = mmio_read_q;
   assign overflow  = overflow_q;
   assign tx_busy   = (state_q != IDLE) || fifo_nonempty;
   assign fifo_full = (count_q == DEPTH_C);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4. Stimulus pushes
// the bytes expected on the line into a queue; a line monitor decodes each
// 8N1 frame and compares it against the queue head.
module tb_uart_tx_mmio;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        Rst;
   logic        mmio_wea;
   logic [31:0] mmio_dat;
   logic        tx;
   logic        mmio_read;
   logic        tx_busy;
   logic        fifo_full;
   logic        overflow;

   int checks      = 0;
   int failures    = 0;
   int cyc         = 0;
   int pulse_total = 0;

   logic [7:0] exp_q[$];
   int         starts[$];
   int         pulses[$];

   uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .Rst      (Rst),
      .mmio_wea (mmio_wea),
      .mmio_dat (mmio_dat),
      .tx       (tx),
      .mmio_read(mmio_read),
      .tx_busy  (tx_busy),
      .fifo_full(fifo_full),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mmio_read === 1'b1) begin
         pulses.push_back(cyc);
         pulse_total++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_neg(input int n, inout bit ab);
      repeat (n) begin
         @(negedge clk);
         if (Rst === 1'b1) ab = 1'b1;
      end
   endtask

   // Line monitor: first negedge with tx low is sample k; bit centres are at
   // k+2, k+6, ... and the stop bit ends so mmio_read is seen at k+40.
   initial begin : monitor
      bit         ab;
      logic       s0, s1;
      logic [7:0] b;
      logic [7:0] e;
      @(negedge clk);
      forever begin
         if (tx !== 1'b0 || Rst !== 1'b0) begin
            @(negedge clk);
            continue;
         end
         ab = 1'b0;
         b  = '0;
         starts.push_back(cyc);
         wait_neg(2, ab);
         s0 = tx;
         for (int i = 0; i < 8; i++) begin
            wait_neg(4, ab);
            b[i] = tx;
         end
         wait_neg(4, ab);
         s1 = tx;
         wait_neg(2, ab);
         if (ab) begin
            exp_q.delete();
            continue;
         end
         chk("frame_start_bit", {31'd0, s0}, 32'd0);
         chk("frame_stop_bit", {31'd0, s1}, 32'd1);
         chk("frame_mmio_read", {31'd0, mmio_read}, 32'd1);
         if (exp_q.size() == 0) begin
            chk("frame_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'd0, b}, {24'd0, e});
         end
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (tx_busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'd0, tx_busy}, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      repeat (2) @(negedge clk);
      Rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin : stim
      logic [7:0] burst4 [6];
      logic [7:0] burst5 [5];
      int         tx_glitch;
      burst4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      burst5 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

      Rst      = 1'b1;
      mmio_wea = 1'b0;
      mmio_dat = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      chk("rst_full", {31'd0, fifo_full}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_read", {31'd0, mmio_read}, 32'd0);
      Rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte, latency and mmio_read timing
      starts.delete();
      pulses.delete();
      mmio_wea = 1'b1;
      mmio_dat = 32'hFFFF_FFA5;
      exp_q.push_back(8'hA5);
      @(negedge clk);
      mmio_wea = 1'b0;
      mmio_dat = '0;
      chk("lat_e0_tx", {31'd0, tx}, 32'd1);
      chk("lat_e0_busy", {31'd0, tx_busy}, 32'd1);
      @(negedge clk);
      chk("lat_e1_tx", {31'd0, tx}, 32'd0);
      wait_idle("single_idle");
      chk("single_pulses", pulses.size(), 32'd1);
      chk("single_read_at_40", pulses[0] - starts[0], 32'd40);

      // Back-to-back frames
      starts.delete();
      pulses.delete();
      mmio_wea = 1'b1;
      mmio_dat = 32'h0000_0000;
      exp_q.push_back(8'h00);
      @(negedge clk);
      mmio_dat = 32'h1234_56FF;
      exp_q.push_back(8'hFF);
      @(negedge clk);
      mmio_wea = 1'b0;
      wait_idle("b2b_idle");
      chk("b2b_frames", starts.size(), 32'd2);
      chk("b2b_no_gap", starts[1] - starts[0], 32'd40);
      chk("b2b_pulses", pulses.size(), 32'd2);
      chk("b2b_pulse_gap", pulses[1] - pulses[0], 32'd40);

      // Overflow: 6 writes while idle, 0x06 dropped
      for (int i = 0; i < 6; i++) begin
         mmio_wea = 1'b1;
         mmio_dat = {24'd0, burst4[i]};
         if (i < 5) exp_q.push_back(burst4[i]);
         @(negedge clk);
      end
      mmio_wea = 1'b0;
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_full", {31'd0, fifo_full}, 32'd1);
      wait_idle("ovf_idle");
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Full FIFO with a write on the STOP->START pop edge
      do_reset();
      chk("ovf_cleared", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         mmio_wea = 1'b1;
         mmio_dat = {24'd0, burst5[i]};
         exp_q.push_back(burst5[i]);
         @(negedge clk);
      end
      mmio_wea = 1'b0;
      repeat (36) @(negedge clk);
      chk("pop_edge_full_pre", {31'd0, fifo_full}, 32'd1);
      chk("pop_edge_ovf_pre", {31'd0, overflow}, 32'd0);
      mmio_wea = 1'b1;
      mmio_dat = 32'h0000_0099;
      @(negedge clk);
      mmio_wea = 1'b0;
      chk("pop_edge_read", {31'd0, mmio_read}, 32'd1);
      chk("pop_edge_full_post", {31'd0, fifo_full}, 32'd0);
      chk("pop_edge_ovf_post", {31'd0, overflow}, 32'd1);
      chk("pop_edge_tx_start", {31'd0, tx}, 32'd0);
      wait_idle("pop_edge_idle");

      // Reset during DATA bit 3
      do_reset();
      for (int i = 0; i < 3; i++) begin
         mmio_wea = 1'b1;
         mmio_dat = 32'h0000_0030 + i;
         exp_q.push_back(8'h30 + 8'(i));
         @(negedge clk);
      end
      mmio_wea = 1'b0;
      repeat (16) @(negedge clk);
      Rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx", {31'd0, tx}, 32'd1);
      chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
      chk("midrst_full", {31'd0, fifo_full}, 32'd0);
      @(negedge clk);
      Rst = 1'b0;
      tx_glitch = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) tx_glitch++;
      end
      chk("midrst_line_quiet", tx_glitch, 32'd0);

      chk("all_bytes_seen", exp_q.size(), 32'd0);
      chk("pulse_total", pulse_total, 32'd13);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
